// File: rtl/serial_frame_rx.sv
// serial_frame_rx: mid-bit sampling serial frame receiver (start, DATA_W data LSB first, optional parity, stop).
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the parity_err check.
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP, BREAK
  } state_t;
  state_t state, state_n;
  logic [1:0] sync_q;
  logic rxd_s, half, full, valid_n, ferr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n, sh_in, data_n;
  assign rxd_s = sync_q[1];
  assign half  = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign full  = cnt == CW'(CLKS_PER_BIT - 1);
  assign busy  = state != IDLE;
  generate
    if (DATA_W > 1) begin : g_sh
      assign sh_in = {rxd_s, shreg[DATA_W-1:1]};
    end else begin : g_sh
      assign sh_in = rxd_s;
    end
  endgenerate
`ifdef SERIAL_RX_PARITY_EN
  logic par, par_n, perr_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      par        <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par        <= par_n;
      parity_err <= perr_n;
    end
`else
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_n   = par;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = rxd_s ? IDLE : START;
      end
      START: if (half) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rxd_s ? IDLE : DATA;
      end
      DATA: if (full) begin
        cnt_n   = '0;
        shreg_n = sh_in;
        idx_n   = idx + IW'(1);
`ifdef SERIAL_RX_PARITY_EN
        if (idx == IW'(DATA_W - 1)) state_n = PARITY;
`else
        if (idx == IW'(DATA_W - 1)) state_n = STOP;
`endif
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: if (full) begin
        cnt_n   = '0;
        par_n   = rxd_s;
        state_n = STOP;
      end
`endif
      STOP: if (full) begin
        cnt_n   = '0;
        state_n = rxd_s ? IDLE : BREAK;
        valid_n = rxd_s;
        ferr_n  = !rxd_s;
        data_n  = rxd_s ? shreg : data;
`ifdef SERIAL_RX_PARITY_EN
        perr_n  = rxd_s & (^shreg ^ par);
`endif
      end
      BREAK: begin
        cnt_n   = '0;
        state_n = rxd_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for serial_frame_rx; expected words queued as frames are driven.
module tb_serial_frame_rx;
  localparam int W   = 8;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic [W-1:0] data;
  logic valid, frame_err, parity_err, busy;
  typedef struct {logic [W-1:0] d; logic pe;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_valid = 0, n_ferr = 0, t0 = 0, lat_arm = 0, last_v = 0, prev_v = 0;

  serial_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic stop, input logic p);
    hold(1'b0, CPB);
    for (int i = 0; i < W; i++) hold(d[i], CPB);
`ifdef SERIAL_RX_PARITY_EN
    hold(p, CPB);
`endif
    hold(stop, CPB);
  endtask

  task automatic push(input logic [W-1:0] d, input logic pe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    sb.push_back(e);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (valid && frame_err) check("strobe_overlap", 1, 0);
    if (frame_err) n_ferr++;
    if (valid) begin
      exp_t e;
      n_valid++;
      prev_v = last_v;
      last_v = cyc;
      if (lat_arm != 0) begin
        check("latency_in_window", 32'((cyc - t0) >= 152 && (cyc - t0) <= 157), 1);
        lat_arm = 0;
      end
      if (sb.size() == 0) check("unexpected_valid", {24'h0, data}, 32'hdead);
      else begin
        e = sb.pop_front();
        check("data", {24'h0, data}, {24'h0, e.d});
        check("parity_err", {31'h0, parity_err}, {31'h0, e.pe});
      end
    end
  end

  initial begin
    int b, v0, f0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data}, 0);
    check("rst_valid", {31'h0, valid}, 0);
    check("rst_frame_err", {31'h0, frame_err}, 0);
    check("rst_parity_err", {31'h0, parity_err}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    rst_n = 1'b1;
    hold(1'b1, 5);

    t0 = cyc;
    lat_arm = 1;
    push(8'hA5, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("latency_seen", lat_arm, 0);
    check("frame_err_clean", n_ferr, 0);

    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    hold(1'b1, 20);
    check("b2b_spacing", 32'((last_v - prev_v) >= 158 && (last_v - prev_v) <= 162), 1);
    check("b2b_count", n_valid, 3);

    v0 = n_valid;
    f0 = n_ferr;
    b  = 0;
    hold(1'b0, 3);
    rxd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) b++;
    end
    check("glitch_busy_bounded", 32'(b >= 1 && b <= 12), 1);
    check("glitch_no_valid", n_valid, v0);
    check("glitch_no_ferr", n_ferr, f0);

    send(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 500);
    check("break_one_ferr", n_ferr, f0 + 1);
    check("break_data_kept", {24'h0, data}, 32'hFF);
    check("break_busy", {31'h0, busy}, 1);
    hold(1'b1, 6);
    check("break_idle", {31'h0, busy}, 0);
    check("break_no_valid", n_valid, v0);

`ifdef SERIAL_RX_PARITY_EN
    push(8'h81, 1'b0);
    send(8'h81, 1'b1, 1'b0);
    push(8'h81, 1'b1);
    send(8'h81, 1'b1, 1'b1);
    hold(1'b1, 20);
    check("parity_count", n_valid, v0 + 2);
    v0 = n_valid;
`endif

    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(i[0] ? 1'b1 : 1'b0, CPB);
    hold(1'b1, CPB / 2);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_data", {24'h0, data}, 0);
    check("midrst_busy", {31'h0, busy}, 0);
    check("midrst_valid", {31'h0, valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 40);
    check("midrst_no_strobe", n_valid, v0);
    push(8'h12, 1'b0);
    send(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    hold(1'b1, 5);
    check("scoreboard_drained", sb.size(), 0);
    check("final_valid_count", n_valid, v0 + 1);
    check("final_data", {24'h0, data}, 32'h12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
